// File: rtl/square_pkg.sv
// Shared types and constants for the square drawer: screen limits, the
// 11-bit coordinate type and the drawer FSM state encoding.
package square_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [10:0] coord_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRelease,
        StErase,
        StDraw,
        StFin
    } state_e;

endpackage

// File: rtl/square_scan.sv
// SIDE x SIDE raster scanner. A start pulse arms the scan, which then emits
// one coordinate per cycle (column inner, row outer) and flags the final one
// with last. Coordinates are origin + offset; in_bounds marks on-screen pixels.
module square_scan
    import square_pkg::*;
#(
    parameter int unsigned SIDE = 16
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  coord_t org_x,
    input  coord_t org_y,
    output logic   active,
    output logic   last,
    output coord_t pix_x,
    output coord_t pix_y,
    output logic   in_bounds
);

    localparam int unsigned CW = (SIDE > 1) ? $clog2(SIDE) : 1;
    localparam logic [CW-1:0] MaxOff = CW'(SIDE - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          active_q, active_d;
    logic          col_end, row_end;
    // One extra bit so origins near 2047 cannot wrap back on-screen.
    logic [11:0]   sum_x, sum_y;

    // Counter advance: start takes priority so a new pass can follow a last
    // coordinate with no gap.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        active_d = active_q;
        col_end  = (col_q == MaxOff);
        row_end  = (row_q == MaxOff);
        if (start) begin
            active_d = 1'b1;
            col_d    = '0;
            row_d    = '0;
        end else if (active_q) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d    = '0;
                    active_d = 1'b0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Origin add and screen clip.
    always_comb begin
        sum_x     = {1'b0, org_x} + 12'(col_q);
        sum_y     = {1'b0, org_y} + 12'(row_q);
        pix_x     = sum_x[10:0];
        pix_y     = sum_y[10:0];
        in_bounds = (sum_x < 12'(SCREEN_W)) && (sum_y < 12'(SCREEN_H));
        active    = active_q;
        last      = active_q && col_end && row_end;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q    <= '0;
            row_q    <= '0;
            active_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/square_drawer.sv
// Square drawer: requests an origin from a location picker, then writes a
// SIDE x SIDE white square one pixel per cycle, clipped to 640x480.
// Define SQUARE_ERASE_EN to erase the previous square (black) before each draw.
module square_drawer
    import square_pkg::*;
#(
    parameter int unsigned SIDE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    output logic        loc_start,
    input  logic        loc_done,
    input  logic [10:0] x_loc,
    input  logic [10:0] y_loc,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_color,
    output logic        pix_we,
    output logic        busy,
    output logic        done
);

    state_e state_q, state_d;
    coord_t org_x_q, org_x_d;
    coord_t org_y_q, org_y_d;

`ifdef SQUARE_ERASE_EN
    coord_t prev_x_q, prev_x_d;
    coord_t prev_y_q, prev_y_d;
    logic   prev_valid_q, prev_valid_d;
`endif

    logic   scan_start;
    logic   scan_active;
    logic   scan_last;
    logic   scan_in_bounds;
    coord_t scan_org_x, scan_org_y;
    coord_t scan_x, scan_y;

    // Next-state logic, origin capture and scan sequencing.
    always_comb begin
        state_d    = state_q;
        org_x_d    = org_x_q;
        org_y_d    = org_y_q;
        scan_start = 1'b0;
`ifdef SQUARE_ERASE_EN
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (go) state_d = StReq;
            end
            StReq: begin
                if (loc_done) begin
                    org_x_d = x_loc;
                    org_y_d = y_loc;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Wait for the picker to fall back to idle before scanning.
                if (!loc_done) begin
                    scan_start = 1'b1;
`ifdef SQUARE_ERASE_EN
                    state_d = prev_valid_q ? StErase : StDraw;
`else
                    state_d = StDraw;
`endif
                end
            end
`ifdef SQUARE_ERASE_EN
            StErase: begin
                if (scan_last) begin
                    scan_start = 1'b1;
                    state_d    = StDraw;
                end
            end
`endif
            StDraw: begin
                if (scan_last) begin
`ifdef SQUARE_ERASE_EN
                    prev_x_d     = org_x_q;
                    prev_y_d     = org_y_q;
                    prev_valid_d = 1'b1;
`endif
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Scanner origin select and Moore-style outputs.
    always_comb begin
`ifdef SQUARE_ERASE_EN
        scan_org_x = (state_q == StErase) ? prev_x_q : org_x_q;
        scan_org_y = (state_q == StErase) ? prev_y_q : org_y_q;
        pix_color  = (state_q == StDraw);
`else
        scan_org_x = org_x_q;
        scan_org_y = org_y_q;
        pix_color  = 1'b1;
`endif
        pix_x     = scan_x;
        pix_y     = scan_y;
        pix_we    = scan_active && scan_in_bounds;
        loc_start = (state_q == StReq);
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
    end

    square_scan #(
        .SIDE(SIDE)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .start    (scan_start),
        .org_x    (scan_org_x),
        .org_y    (scan_org_y),
        .active   (scan_active),
        .last     (scan_last),
        .pix_x    (scan_x),
        .pix_y    (scan_y),
        .in_bounds(scan_in_bounds)
    );

    // State and origin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            org_x_q <= '0;
            org_y_q <= '0;
`ifdef SQUARE_ERASE_EN
            prev_x_q     <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            org_x_q <= org_x_d;
            org_y_q <= org_y_d;
`ifdef SQUARE_ERASE_EN
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_square_drawer.sv
// Bench for square_drawer: behavioural location picker, negedge output monitor,
// table-driven runs, reset/go corner sequences and random origins checked
// against a pixel-list model of the expected writes.
module tb_square_drawer;

    localparam int SIDE = 16;
`ifdef SQUARE_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } pix_t;

    typedef struct {
        string nm;
        int    ox;
        int    oy;
        int    dly;
        int    hld;
        int    exp_draw;
        bit    mid_go;
    } vec_t;

    logic        clk, reset, go;
    logic        loc_start, loc_done;
    logic [10:0] x_loc, y_loc, pix_x, pix_y;
    logic        pix_color, pix_we, busy, done;

    square_drawer #(
        .SIDE(SIDE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .loc_start(loc_start),
        .loc_done (loc_done),
        .x_loc    (x_loc),
        .y_loc    (y_loc),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_color(pix_color),
        .pix_we   (pix_we),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Picker: idle -> run (pick_d cycles) -> finished, holding loc_done while
    // loc_start=1 and for pick_h further cycles, then back to idle.
    int pick_x = 0, pick_y = 0, pick_d = 0, pick_h = 0;
    int p_st = 0, p_cnt = 0, p_hold = 0;
    initial begin
        loc_done = 1'b0;
        x_loc    = '0;
        y_loc    = '0;
    end
    always @(posedge clk) begin
        #1;
        case (p_st)
            0: if (loc_start) begin p_st = 1; p_cnt = pick_d; end
            1: if (p_cnt == 0) begin p_st = 2; p_hold = pick_h; end
               else p_cnt--;
            default: if (!loc_start) begin
                if (p_hold > 0) p_hold--;
                else p_st = 0;
            end
        endcase
        loc_done = (p_st == 2);
        if (loc_done) begin
            x_loc = 11'(pick_x);
            y_loc = 11'(pick_y);
        end else begin
            x_loc = 11'($urandom_range(0, 2047));
            y_loc = 11'($urandom_range(0, 2047));
        end
    end

    // Monitor: sampled at negedge, mid-cycle.
    pix_t got_q[$];
    pix_t mp;
    int done_cnt = 0, free_cnt = 0, ovl_cnt = 0, hold_we_cnt = 0;
    always @(negedge clk) begin
        if (pix_we) begin
            mp.x = pix_x;
            mp.y = pix_y;
            mp.c = pix_color;
            got_q.push_back(mp);
        end
        if (done) done_cnt++;
        if (busy && !loc_start && !loc_done) free_cnt++;
        if (loc_start && loc_done) ovl_cnt++;
        if (pix_we && loc_done) hold_we_cnt++;
    end

    int   n_cmp = 0, n_bad = 0;
    pix_t exp_q[$];
    bit   prev_valid_m = 1'b0;
    int   prev_x_m = 0, prev_y_m = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Every on-screen pixel of a SIDE x SIDE square in raster order.
    function automatic void model_pass(input int ox, input int oy, input logic c);
        pix_t p;
        for (int r = 0; r < SIDE; r++) begin
            for (int col = 0; col < SIDE; col++) begin
                if (ox + col < 640 && oy + r < 480) begin
                    p.x = 11'(ox + col);
                    p.y = 11'(oy + r);
                    p.c = c;
                    exp_q.push_back(p);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_sq(input string nm, input int ox, input int oy, input int dly,
                          input int hld, input int exp_draw, input bit mid_go);
        int   base, d0, f0, o0, h0, passes, dc, bad_i, n1;
        bit   seen, pulsed, go_hi;
        pix_t g;
        pick_x = ox;
        pick_y = oy;
        pick_d = dly;
        pick_h = hld;
        exp_q.delete();
        passes = (ERASE_EN && prev_valid_m) ? 2 : 1;
        if (passes == 2) model_pass(prev_x_m, prev_y_m, 1'b0);
        model_pass(ox, oy, 1'b1);
        base = got_q.size();
        d0 = done_cnt; f0 = free_cnt; o0 = ovl_cnt; h0 = hold_we_cnt;
        tick(); go = 1'b1;
        tick(); go = 1'b0;
        seen = 0; pulsed = 0; go_hi = 0; dc = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            tick();
            if (go_hi) begin go = 1'b0; go_hi = 0; end
            if (pix_we && pix_color) dc++;
            if (mid_go && !pulsed && dc == 10) begin go = 1'b1; go_hi = 1; pulsed = 1; end
            if (done) seen = 1;
        end
        go = 1'b0;
        chk({nm, " done_seen"}, int'(seen), 1);
        repeat (3) tick();
        n1 = 0;
        for (int i = base; i < got_q.size(); i++) if (got_q[i].c) n1++;
        if (exp_draw >= 0) chk({nm, " draw_writes"}, n1, exp_draw);
        chk({nm, " total_writes"}, got_q.size() - base, exp_q.size());
        bad_i = -1;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            if (bad_i < 0 && got_q[base + i] != exp_q[i]) bad_i = i;
        end
        n_cmp++;
        if (bad_i >= 0) begin
            n_bad++;
            g = got_q[base + bad_i];
            $display("FAIL %s pixel[%0d]: got (%0d,%0d,c%0d), expected (%0d,%0d,c%0d)",
                     nm, bad_i, g.x, g.y, g.c, exp_q[bad_i].x, exp_q[bad_i].y, exp_q[bad_i].c);
        end
        chk({nm, " done_pulses"}, done_cnt - d0, 1);
        chk({nm, " scan_cycles"}, free_cnt - f0, SIDE * SIDE * passes + 2);
        chk({nm, " req_overlap"}, ovl_cnt - o0, 1);
        chk({nm, " we_in_hold"}, hold_we_cnt - h0, 0);
        chk({nm, " busy_after"}, int'(busy), 0);
        prev_x_m = ox;
        prev_y_m = oy;
        prev_valid_m = 1'b1;
    endtask

    // Reset on the 40th DRAW cycle of a fully on-screen square.
    task automatic reset_mid_draw();
        int  dc, d0;
        bit  hit;
        pick_x = 200; pick_y = 100; pick_d = 1; pick_h = 0;
        d0 = done_cnt;
        tick(); go = 1'b1;
        tick(); go = 1'b0;
        dc = 0; hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            tick();
            if (pix_we && pix_color) dc++;
            if (dc == 40) hit = 1;
        end
        chk("rst_draw reached40", int'(hit), 1);
        reset = 1'b1;
        tick();
        chk("rst_draw busy", int'(busy), 0);
        chk("rst_draw pix_we", int'(pix_we), 0);
        chk("rst_draw done", int'(done), 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_draw no_done", done_cnt - d0, 0);
        prev_valid_m = 1'b0;
    endtask

    // Reset while the picker is still working; it must drain by itself.
    task automatic reset_mid_req();
        int  w0;
        bit  hit;
        pick_x = 7; pick_y = 7; pick_d = 10; pick_h = 0;
        tick(); go = 1'b1;
        tick(); go = 1'b0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (loc_start) hit = 1;
        end
        chk("rst_req loc_start_seen", int'(hit), 1);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_req loc_start", int'(loc_start), 0);
        chk("rst_req busy", int'(busy), 0);
        reset = 1'b0;
        w0 = got_q.size();
        repeat (20) tick();
        chk("rst_req idle_writes", got_q.size() - w0, 0);
        chk("rst_req still_idle", int'(busy), 0);
        chk("rst_req picker_idle", int'(loc_done), 0);
        prev_valid_m = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{"origin_100_200", 100, 200, 2, 0, 256, 1'b0};
        tbl[1]  = '{"clip_630_470",   630, 470, 0, 0, 100, 1'b0};
        tbl[2]  = '{"origin_50_50",    50,  50, 1, 0, 256, 1'b0};
        tbl[3]  = '{"origin_0_0",       0,   0, 3, 0, 256, 1'b0};
        tbl[4]  = '{"hold5_624_464",  624, 464, 0, 5, 256, 1'b0};
        tbl[5]  = '{"corner_639_479", 639, 479, 1, 0,   1, 1'b0};
        tbl[6]  = '{"offscr_640_0",   640,   0, 0, 1,   0, 1'b0};
        tbl[7]  = '{"clip_625_0",     625,   0, 2, 0, 240, 1'b0};
        tbl[8]  = '{"clip_0_470",       0, 470, 0, 2, 160, 1'b0};
        tbl[9]  = '{"nowrap_2040",   2040, 2040, 1, 0,  0, 1'b0};
        tbl[10] = '{"go_in_draw",     320, 240, 1, 0, 256, 1'b1};

        go = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk("reset busy", int'(busy), 0);
        chk("reset loc_start", int'(loc_start), 0);
        chk("reset pix_we", int'(pix_we), 0);
        chk("reset done", int'(done), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_sq(tbl[i].nm, tbl[i].ox, tbl[i].oy, tbl[i].dly, tbl[i].hld,
                   tbl[i].exp_draw, tbl[i].mid_go);
        end

        reset_mid_draw();
        run_sq("after_rst_draw", 300, 300, 1, 0, 256, 1'b0);
        reset_mid_req();
        run_sq("after_rst_req", 10, 20, 0, 0, 256, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_sq($sformatf("rand%0d", i), int'($urandom_range(0, 700)),
                   int'($urandom_range(0, 520)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/square_drawer.md
SQUARE_DRAWER -- requirements
Module: square_drawer

Interface
REQ-001 SHALL have parameter SIDE, default 16: square edge length in pixels, range 1..64.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port go, input, 1: request one new square; sampled only in IDLE.
REQ-005 SHALL have port loc_start, output, 1: location request to the picker; level, held until the picker answers.
REQ-006 SHALL have port loc_done, input, 1: picker has a location ready; level.
REQ-007 SHALL have port x_loc, input, 11: square origin X from the picker; valid while loc_done=1.
REQ-008 SHALL have port y_loc, input, 11: square origin Y from the picker; valid while loc_done=1.
REQ-009 SHALL have port pix_x, output, 11: pixel write X.
REQ-010 SHALL have port pix_y, output, 11: pixel write Y.
REQ-011 SHALL have port pix_color, output, 1: 1 means draw (white), 0 means erase (black).
REQ-012 SHALL have port pix_we, output, 1: pixel write strobe, one pixel per cycle.
REQ-013 SHALL have port busy, output, 1: high from leaving IDLE until returning to IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse in the cycle after the last DRAW pixel.

Function
REQ-015 SHALL implement states IDLE, REQ, RELEASE, ERASE, DRAW, FIN.
REQ-016 IDLE: go=1 -> REQ next cycle; otherwise stay in IDLE; go in any other state SHALL be ignored.
REQ-017 REQ: loc_start=1; on loc_done=1, latch x_loc/y_loc into origin registers -> RELEASE.
REQ-018 RELEASE: loc_start=0; wait for loc_done=0, then go to ERASE if erase is enabled and a previous square exists, else to DRAW.
REQ-019 ERASE/DRAW SHALL scan the previous/current origin in raster order: column offset from 0 to SIDE-1 inner, row offset from 0 to SIDE-1 outer; one coordinate per cycle; exactly SIDE*SIDE cycles.
REQ-020 pix_x = origin_x + col and pix_y = origin_y + row, computed at 11 bits with no wrap.
REQ-021 pix_we SHALL be 1 only for ERASE/DRAW cycles where pix_x<640 and pix_y<480; clipped pixels SHALL still consume their cycle.
REQ-022 pix_color SHALL be 0 in ERASE and 1 in DRAW; pix_x/pix_y/pix_color are don't-care when pix_we=0.
REQ-023 ERASE end -> DRAW; DRAW end -> FIN; when DRAW completes, origin SHALL be copied to prev origin and prev_valid set to 1.
REQ-024 FIN: done=1 for exactly one cycle -> IDLE.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 If loc_done=1 while in IDLE, it SHALL be ignored (no latch, no request).

Reset
REQ-027 reset SHALL force state IDLE, loc_start=0, pix_we=0, done=0, busy=0, prev_valid=0, and origin/prev origin/scan counters=0, including mid-ERASE/DRAW.
REQ-028 Reset mid-REQ SHALL drop loc_start in the cycle after reset is sampled; a picker left in its finished state SHALL recover on its own once loc_start=0.

Configuration
REQ-029 With macro SQUARE_ERASE_EN defined, the ERASE pass of REQ-018 SHALL be compiled in, so only the newest square stays on screen.
REQ-030 Without SQUARE_ERASE_EN, the ERASE state and prev origin registers SHALL be absent, RELEASE SHALL go straight to DRAW, and pix_color SHALL be constant 1.

Structure
REQ-031 Package square_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, typedef coord_t (logic [10:0]), and the state enum.
REQ-032 Sub-module square_scan SHALL hold the SIDE x SIDE raster counter, the origin add, and the clip compare; it SHALL have start/last handshake signals; ERASE and DRAW SHALL share one instance.

Verification (bench includes a behavioural picker: idle -> run -> finished, holding finished while start=1)
REQ-033 Picker returns (100,200), SIDE=16 -> 256 pix_we cycles covering x 100..115 and y 200..215 in raster order, pix_color=1, then done pulses once.
REQ-034 Origin (630,470), SIDE=16 -> 256 scan cycles, 100 pix_we cycles (x 630..639, y 470..479), then done.
REQ-035 With SQUARE_ERASE_EN, origin (50,50) followed by go with origin (0,0) -> second run erases 50..65 with color 0 before drawing 0..15; without the macro, no color-0 writes.
REQ-036 Picker holds loc_done=1 for 5 extra cycles -> drawer stays in RELEASE, no pix_we until loc_done=0; loc_start low throughout RELEASE.
REQ-037 Reset asserted at the 40th DRAW cycle -> next cycle IDLE, pix_we=0, busy=0, and the next go draws with no ERASE pass.
REQ-038 go pulsed during DRAW -> ignored; exactly one done pulse.
